rr_mux_stage: RTL and testbench

Registered N-channel selector with valid/ready handshakes. It merges N producer streams of WIDTH bits into one consumer stream through a single output register. Arbitration is round-robin by default and can be overridden by a manual select. It sits between datapath sources (ALU/memory results, GPIO and FACT accelerator read-back) and shared sinks, replacing plain combinational selectors where sources are independently timed.

---
 rtl/rr_mux_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/rr_mux_stage.sv | 90 +++++++++
 tb/tb_rr_mux_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin registered selector and its arbiter.
package rr_mux_pkg;

  localparam int PTR_RESET = 0;

  // Ceiling log2 for tools without $clog2; valid for n >= 2.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or a fixed manual choice.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            man_en,
  input  logic [SELW-1:0] man_sel,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    if (man_en) begin
      // A man_sel beyond N-1 never matches, so it yields no grant.
      for (int i = 0; i < N; i++) begin
        if (man_sel == SELW'(i) && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = SELW'(i);
          any     = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!any && req[(int'(ptr) + k) % N]) begin
          gnt[(int'(ptr) + k) % N] = 1'b1;
          gnt_idx = SELW'((int'(ptr) + k) % N);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_mux_stage.sv
// Registered N-channel selector with valid/ready on every side; 1-cycle latency,
// refills while draining, and asserts no in_ready while the output is stalled.
module rr_mux_stage
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic               man_en,
  input  logic [SELW-1:0]    man_sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic [N-1:0]     gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             any;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .man_en  (man_en),
    .man_sel (man_sel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign load     = ~out_valid_q | out_ready;
  assign xfer     = load & any & ~rst;
  assign in_ready = xfer ? gnt : '0;

  // Data is steered by the one-hot grant and only ever reaches the register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = gnt_idx;
      if (!man_en) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= SELW'(PTR_RESET);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_stage.sv
// Scoreboarded bench for rr_mux_stage: 4x32 instance plus a 2x8 instance.
module tb_rr_mux_stage;

  typedef struct packed {logic [1:0] sel; logic [31:0] dat;} exp_t;
  typedef struct packed {logic sel; logic [7:0] dat;} exp2_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         man_en;
  logic [1:0]   man_sel;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [1:0]   in_valid2;
  logic [15:0]  in_data2;
  logic [1:0]   in_ready2;
  logic         man_en2;
  logic         man_sel2;
  logic         out_valid2;
  logic [7:0]   out_data2;
  logic         out_sel2;
  logic         out_ready2;

  exp_t         sb[$];
  exp2_t        sb2[$];
  logic [31:0]  pq[4][$];
  logic [3:0]   acc = '0;
  int           errors = 0;
  int           checks = 0;

  rr_mux_stage #(.WIDTH(32), .N(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .man_en(man_en), .man_sel(man_sel), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  rr_mux_stage #(.WIDTH(8), .N(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .man_en(man_en2), .man_sel(man_sel2), .out_valid(out_valid2), .out_data(out_data2),
    .out_sel(out_sel2), .out_ready(out_ready2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_word(input logic [1:0] s, input logic [31:0] d);
    sb.push_back(exp_t'{sel: s, dat: d});
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || pq[0].size() != 0 || pq[1].size() != 0 ||
            pq[2].size() != 0 || pq[3].size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: timeout with %0d words outstanding, expected 0", name, sb.size());
    end
  endtask

  // Producer model: each channel presents the head of its queue until accepted.
  initial begin
    in_valid = '0;
    in_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        in_valid[i] = (pq[i].size() > 0);
        in_data[i*32 +: 32] = (pq[i].size() > 0) ? pq[i][0] : 32'h0;
      end
    end
  end

  // Monitor: samples on the falling edge, checks every accepted output word.
  initial begin
    exp_t  e;
    exp2_t e2;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      chk("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got sel=%0d data=%0h expected none", out_sel, out_data);
        end else begin
          e = sb.pop_front();
          chk("out_sel", 32'(out_sel), 32'(e.sel));
          chk("out_data", out_data, e.dat);
        end
      end
      if (!rst && out_valid2 && out_ready2) begin
        if (sb2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word2: got sel=%0d data=%0h expected none", out_sel2, out_data2);
        end else begin
          e2 = sb2.pop_front();
          chk("out_sel2", 32'(out_sel2), 32'(e2.sel));
          chk("out_data2", 32'(out_data2), 32'(e2.dat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    man_en     = 1'b0;
    man_sel    = 2'd0;
    out_ready  = 1'b1;
    in_valid2  = '0;
    in_data2   = '0;
    man_en2    = 1'b0;
    man_sel2   = 1'b0;
    out_ready2 = 1'b0;

    // Full-load round robin: two words per channel, presented during reset.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        pq[i].push_back(32'hA0 + 32'(i));
        expect_word(2'(i), 32'hA0 + 32'(i));
      end
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    repeat (8) tick();
    chk("full_rate_outstanding", 32'(sb.size()), 32'd1);
    wait_drain("rr_full");

    // Bring ptr to 3 via ch2, then ch2+ch3 together: ch3 first, wrap, ch2.
    pq[2].push_back(32'hB2);
    expect_word(2'd2, 32'hB2);
    wait_drain("ptr_to_3");
    pq[2].push_back(32'hC2);
    pq[3].push_back(32'hC3);
    expect_word(2'd3, 32'hC3);
    expect_word(2'd2, 32'hC2);
    wait_drain("wrap");

    // Stall five cycles with D0 held; D2 waits behind it.
    out_ready = 1'b0;
    pq[0].push_back(32'hD0);
    pq[2].push_back(32'hD2);
    expect_word(2'd0, 32'hD0);
    expect_word(2'd2, 32'hD2);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", out_data, 32'hD0);
      chk("stall_out_sel", 32'(out_sel), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("stall_release");

    // Manual select ch1 with ptr at 3; afterwards round robin resumes from 3.
    man_en  = 1'b1;
    man_sel = 2'd1;
    for (int i = 0; i < 4; i++) pq[i].push_back(32'hE0 + 32'(i));
    expect_word(2'd1, 32'hE1);
    repeat (6) tick();
    chk("manual_single_word", 32'(sb.size()), 32'd0);
    chk("manual_drained_valid", 32'(out_valid), 32'd0);
    chk("manual_blocked_ready", 32'(in_ready), 32'd0);
    man_en = 1'b0;
    expect_word(2'd3, 32'hE3);
    expect_word(2'd0, 32'hE0);
    expect_word(2'd2, 32'hE2);
    wait_drain("manual_ptr_kept");

    // Reset during a stall: F2 is lost, ptr restarts at 0 so F0 precedes F3.
    out_ready = 1'b0;
    pq[2].push_back(32'hF2);
    repeat (3) tick();
    chk("pre_rst_out_data", out_data, 32'hF2);
    pq[0].push_back(32'hF0);
    pq[3].push_back(32'hF3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    chk("async_rst_out_sel", 32'(out_sel), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    expect_word(2'd0, 32'hF0);
    expect_word(2'd3, 32'hF3);
    wait_drain("post_rst");

    // Two-channel build: strict alternation under full load.
    for (int r = 0; r < 2; r++) begin
      sb2.push_back(exp2_t'{sel: 1'b0, dat: 8'h10});
      sb2.push_back(exp2_t'{sel: 1'b1, dat: 8'h11});
    end
    in_data2   = 16'h1110;
    in_valid2  = 2'b11;
    out_ready2 = 1'b1;
    repeat (4) tick();
    in_valid2 = 2'b00;
    repeat (3) tick();
    chk("n2_outstanding", 32'(sb2.size()), 32'd0);
    chk("n2_drained_valid", 32'(out_valid2), 32'd0);

    repeat (3) tick();
    chk("final_outstanding", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
